// File: rtl/sbus_arbiter.sv
// ============================================================================
//  Module   : sbus_arbiter
//  Purpose  : Two-master (I-fetch, D-memory) to one-slave sbus arbiter with
//             grant locking across stalls and D-priority with I starvation guard.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sbus_arbiter #(
   parameter int D_STREAK_MAX = 4,
   parameter int CNT_W        = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_en,
   input  logic        i_we,
   input  logic [1:0]  i_size,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_data_w,
   output logic [31:0] i_data_r,
   output logic        i_stall,
   input  logic        d_en,
   input  logic        d_we,
   input  logic [1:0]  d_size,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_data_w,
   output logic [31:0] d_data_r,
   output logic        d_stall,
   output logic        s_en,
   output logic        s_we,
   output logic [1:0]  s_size,
   output logic [31:0] s_addr,
   output logic [31:0] s_data_w,
   input  logic [31:0] s_data_r,
   input  logic        s_stall,
   output logic [1:0]  owner
);

   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_I    = 2'b01,
      OWN_D    = 2'b10
   } own_t;

   localparam logic [CNT_W-1:0] C_STREAK_MAX = CNT_W'(D_STREAK_MAX);

   own_t             own_q, own_d;
   own_t             w_sel;
   logic [CNT_W-1:0] streak_q, streak_d;
   logic             w_i_done;
   logic             w_d_done;

   // Selection never looks at s_stall, so the grant is stable within a cycle.
   always_comb begin
      w_sel = OWN_NONE;
      case (own_q)
         OWN_I:   w_sel = OWN_I;
         OWN_D:   w_sel = OWN_D;
         default: begin
            if (i_en && d_en)
               w_sel = (streak_q == C_STREAK_MAX) ? OWN_I : OWN_D;
            else if (i_en)
               w_sel = OWN_I;
            else if (d_en)
               w_sel = OWN_D;
         end
      endcase
   end

   always_comb begin
      s_en     = 1'b0;
      s_we     = 1'b0;
      s_size   = 2'b00;
      s_addr   = 32'h0;
      s_data_w = 32'h0;
      i_stall  = i_en;
      d_stall  = d_en;
      if (!rst) begin
         case (w_sel)
            OWN_I: begin
               s_en     = i_en;
               s_we     = i_we;
               s_size   = i_size;
               s_addr   = i_addr;
               s_data_w = i_data_w;
               i_stall  = s_stall;
            end
            OWN_D: begin
               s_en     = d_en;
               s_we     = d_we;
               s_size   = d_size;
               s_addr   = d_addr;
               s_data_w = d_data_w;
               d_stall  = s_stall;
            end
            default: ;
         endcase
      end
   end

   assign i_data_r = s_data_r;
   assign d_data_r = s_data_r;
   assign owner    = own_q;

   assign w_i_done = !rst && (w_sel == OWN_I) && i_en && !s_stall;
   assign w_d_done = !rst && (w_sel == OWN_D) && d_en && !s_stall;

   always_comb begin
      own_d    = own_q;
      streak_d = streak_q;

      case (own_q)
         OWN_I:   if (!i_en || !s_stall) own_d = OWN_NONE;
         OWN_D:   if (!d_en || !s_stall) own_d = OWN_NONE;
         default: if ((w_sel != OWN_NONE) && s_stall) own_d = w_sel;
      endcase

      // Clearing wins over counting: an idle or served I resets the streak.
      if (!i_en || w_i_done)
         streak_d = '0;
      else if (w_d_done && (streak_q != C_STREAK_MAX))
         streak_d = streak_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         own_q    <= OWN_NONE;
         streak_q <= '0;
      end else begin
         own_q    <= own_d;
         streak_q <= streak_d;
      end
   end

endmodule

`default_nettype wire
